// File: rtl/wash_timer_scheduler_if.sv
// wash_timer_scheduler_if: controller-side request/status bundle for the wash timer scheduler
interface wash_timer_scheduler_if;
  logic cycle_req;
  logic spin_req;
  logic fill_value_on;
  logic pause;
  logic prog_load;
  logic [1:0] prog_sel;
  logic cycle_timeout;
  logic spin_timeout;
  logic busy;
  logic req_conflict;
  logic prog_err;
  logic fill_fault;
  logic [7:0] remaining;
  logic [2:0] phase;
  modport master (
    output cycle_req, spin_req, fill_value_on, pause, prog_load, prog_sel,
    input cycle_timeout, spin_timeout, busy, req_conflict, prog_err, fill_fault, remaining, phase
  );
  modport slave (
    input cycle_req, spin_req, fill_value_on, pause, prog_load, prog_sel,
    output cycle_timeout, spin_timeout, busy, req_conflict, prog_err, fill_fault, remaining, phase
  );
endinterface

// File: rtl/wash_timer_scheduler.sv
// wash_timer_scheduler: program-driven wash/spin phase timer; define FILL_WATCHDOG_EN to add a sticky fill-valve watchdog
module wash_timer_scheduler #(
  parameter int PRESCALE = 1000,
  parameter int FILL_LIMIT = 60
) (
  input logic clk,
  input logic reset,
  wash_timer_scheduler_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CYC_RUN = 3'd1,
    CYC_DONE = 3'd2,
    SPIN_RUN = 3'd3,
    SPIN_DONE = 3'd4,
    CONFLICT = 3'd5
  } state_t;
  state_t state, state_n;
  logic [15:0] presc, presc_n;
  logic [7:0] rem, rem_n;
  logic [7:0] cyc_ticks, spin_ticks;
  logic [1:0] prog;
  logic cyc_q, spin_q, err_q, fault;
  logic run, tick, both, cyc_rise, spin_rise, idle_load;
  if (PRESCALE < 2 || PRESCALE > 65535 || FILL_LIMIT < 1) begin : g_param_check
    $error("wash_timer_scheduler: PRESCALE must be 2..65535 and FILL_LIMIT at least 1");
  end
  assign cyc_ticks = prog == 2'd0 ? 8'd20 : prog == 2'd2 ? 8'd80 : 8'd40;
  assign spin_ticks = prog == 2'd0 ? 8'd10 : prog == 2'd2 ? 8'd30 : 8'd20;
  assign run = state == CYC_RUN || state == SPIN_RUN;
  assign tick = run && !bus.pause && presc == 16'(PRESCALE - 1);
  assign both = bus.cycle_req && bus.spin_req;
  assign cyc_rise = bus.cycle_req && !cyc_q;
  assign spin_rise = bus.spin_req && !spin_q;
  assign idle_load = state == IDLE && bus.prog_load;
  always_comb begin
    state_n = state;
    rem_n = rem;
    presc_n = tick ? '0 : (run && !bus.pause) ? presc + 16'd1 : presc;
    if (both && !(state == IDLE && fault)) begin
      state_n = CONFLICT;
      rem_n = '0;
      presc_n = '0;
    end else
      case (state)
        IDLE:
          if (!fault && cyc_rise && !bus.spin_req) begin
            state_n = CYC_RUN;
            rem_n = cyc_ticks;
            presc_n = '0;
          end else if (!fault && spin_rise && !bus.cycle_req) begin
            state_n = SPIN_RUN;
            rem_n = spin_ticks;
            presc_n = '0;
          end
        CYC_RUN, SPIN_RUN:
          if (!(state == CYC_RUN ? bus.cycle_req : bus.spin_req)) begin
            state_n = IDLE;
            rem_n = '0;
            presc_n = '0;
          end else if (tick) begin
            rem_n = rem - 8'd1;
            if (rem == 8'd1 && state == CYC_RUN) state_n = CYC_DONE;
            if (rem == 8'd1 && state == SPIN_RUN) state_n = SPIN_DONE;
          end
        CYC_DONE: if (!bus.cycle_req) state_n = IDLE;
        SPIN_DONE: if (!bus.spin_req) state_n = IDLE;
        CONFLICT: if (!bus.cycle_req && !bus.spin_req) state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  // request history resets high so a request already held at reset release must drop and re-rise
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rem <= '0;
      presc <= '0;
      prog <= 2'd1;
      cyc_q <= 1'b1;
      spin_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      presc <= presc_n;
      cyc_q <= bus.cycle_req;
      spin_q <= bus.spin_req;
      err_q <= idle_load && bus.prog_sel == 2'd3;
      if (idle_load && bus.prog_sel != 2'd3) prog <= bus.prog_sel;
    end
`ifdef FILL_WATCHDOG_EN
  localparam int W = $clog2(FILL_LIMIT + 1);
  logic [15:0] wd_presc;
  logic [W-1:0] wd_cnt;
  logic wd_tick;
  assign wd_tick = wd_presc == 16'(PRESCALE - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wd_presc <= '0;
      wd_cnt <= '0;
      fault <= 1'b0;
    end else begin
      wd_presc <= wd_tick ? '0 : wd_presc + 16'd1;
      wd_cnt <= !bus.fill_value_on ? '0 : (wd_tick && wd_cnt != W'(FILL_LIMIT)) ? wd_cnt + W'(1) : wd_cnt;
      fault <= fault || wd_cnt == W'(FILL_LIMIT);
    end
`else
  assign fault = 1'b0;
`endif
  assign bus.phase = state;
  assign bus.remaining = rem;
  assign bus.busy = run;
  assign bus.cycle_timeout = state == CYC_DONE && !fault;
  assign bus.spin_timeout = state == SPIN_DONE && !fault;
  assign bus.req_conflict = state == CONFLICT;
  assign bus.prog_err = err_q;
  assign bus.fill_fault = fault;
endmodule

// File: tb/tb_wash_timer_scheduler.sv
// tb_wash_timer_scheduler: vector table, reset/fill sequences and random traffic against a clock-counting reference model
module tb_wash_timer_scheduler;
  localparam int P = 4;
`ifdef FILL_WATCHDOG_EN
  localparam bit FF_EXP = 1'b1;
`else
  localparam bit FF_EXP = 1'b0;
`endif
  typedef struct {
    bit c, s, p, l;
    logic [1:0] sel;
    int n, ph, rem;
    bit err;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, passed = 0;
  int m_ph, m_prog, m_n, m_act;
  bit m_cl, m_sl, m_err;
  int ctab[3] = '{20, 40, 80};
  int stab[3] = '{10, 20, 30};
  vec_t tv[$];
  wash_timer_scheduler_if bus();
  wash_timer_scheduler #(.PRESCALE(P), .FILL_LIMIT(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic model_reset();
    m_ph = 0; m_prog = 1; m_n = 0; m_act = 0; m_cl = 0; m_sl = 0; m_err = 0;
  endtask
  // phases: 0 idle, 1 cycle run, 2 cycle done, 3 spin run, 4 spin done, 5 conflict
  task automatic model_edge();
    bit c = bus.cycle_req, s = bus.spin_req;
    int t = m_ph;
    m_err = m_ph == 0 && bus.prog_load && bus.prog_sel == 2'd3;
    if (c && s) t = 5;
    else if (m_ph == 0) begin
      if (c && m_cl) begin t = 1; m_n = ctab[m_prog]; m_act = 0; end
      else if (s && m_sl) begin t = 3; m_n = stab[m_prog]; m_act = 0; end
    end else if (m_ph == 1 || m_ph == 3) begin
      if (!(m_ph == 1 ? c : s)) t = 0;
      else if (!bus.pause) begin
        m_act++;
        if (m_act == m_n * P) t = m_ph + 1;
      end
    end else if (m_ph == 2 || m_ph == 4) begin
      if (!(m_ph == 2 ? c : s)) t = 0;
    end else if (!c && !s) t = 0;
    if (m_ph == 0 && bus.prog_load && bus.prog_sel != 2'd3) m_prog = int'(bus.prog_sel);
    m_cl = !c; m_sl = !s; m_ph = t;
  endtask
  task automatic chk_model();
    int r = (m_ph == 1 || m_ph == 3) ? m_n - m_act / P : 0;
    chk("phase", bus.phase, m_ph);
    chk("remaining", bus.remaining, r);
    chk("busy", bus.busy, m_ph == 1 || m_ph == 3);
    chk("cycle_timeout", bus.cycle_timeout, m_ph == 2);
    chk("spin_timeout", bus.spin_timeout, m_ph == 4);
    chk("req_conflict", bus.req_conflict, m_ph == 5);
    chk("prog_err", bus.prog_err, m_err);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_model();
  endtask
  task automatic add(bit c, s, p, l, logic [1:0] sel, int n, ph, rem, bit err);
    vec_t v;
    v.c = c; v.s = s; v.p = p; v.l = l; v.sel = sel; v.n = n; v.ph = ph; v.rem = rem; v.err = err;
    tv.push_back(v);
  endtask
  task automatic drive(bit c, s, p, l, logic [1:0] sel);
    bus.cycle_req = c; bus.spin_req = s; bus.pause = p; bus.prog_load = l; bus.prog_sel = sel;
  endtask
  initial begin
    reset = 1'b0;
    bus.fill_value_on = 1'b0;
    drive(0, 0, 0, 0, 2'd0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(1,0,0,0,0,   1,1,40,0);
    add(1,0,0,0,0, 159,1, 1,0);
    add(1,0,0,0,0,   1,2, 0,0);
    add(1,0,1,0,0,   5,2, 0,0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(0,0,0,1,0,   1,0, 0,0);
    add(0,1,0,0,0,   1,3,10,0);
    add(0,1,0,0,0,  39,3, 1,0);
    add(0,1,0,0,0,   1,4, 0,0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(0,0,0,1,3,   1,0, 0,1);
    add(0,0,0,0,0,   1,0, 0,0);
    add(0,1,0,0,0,  41,4, 0,0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(1,1,0,0,0,   1,5, 0,0);
    add(1,0,0,0,0,   3,5, 0,0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(0,0,0,1,1,   1,0, 0,0);
    add(1,0,0,0,0,   1,1,40,0);
    add(1,0,0,0,0,  60,1,25,0);
    add(1,0,1,0,0,  10,1,25,0);
    add(1,0,0,0,0,  99,1, 1,0);
    add(1,0,0,0,0,   1,2, 0,0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(1,0,0,0,0,   1,1,40,0);
    add(1,0,0,0,0,  49,1,28,0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(1,0,0,0,0,   1,1,40,0);
    add(1,0,0,1,0,   1,1,40,0);
    add(1,0,1,1,3,   3,1,40,0);
    add(0,0,0,0,0,   1,0, 0,0);
    add(1,0,0,0,0,   1,1,40,0);
    add(1,0,0,0,0,   4,1,39,0);
    add(0,0,0,0,0,   1,0, 0,0);
    repeat (2) @(negedge clk);
    chk("reset phase", bus.phase, 0);
    chk("reset remaining", bus.remaining, 0);
    chk("reset outputs", {bus.busy, bus.cycle_timeout, bus.spin_timeout, bus.req_conflict, bus.prog_err, bus.fill_fault}, 0);
    model_reset();
    reset = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].c, tv[i].s, tv[i].p, tv[i].l, tv[i].sel);
      repeat (tv[i].n) step();
      chk($sformatf("vec%0d phase", i), bus.phase, tv[i].ph);
      chk($sformatf("vec%0d remaining", i), bus.remaining, tv[i].rem);
      chk($sformatf("vec%0d prog_err", i), bus.prog_err, tv[i].err);
      chk($sformatf("vec%0d timeouts", i), {bus.cycle_timeout, bus.spin_timeout}, {tv[i].ph == 2, tv[i].ph == 4});
      chk($sformatf("vec%0d req_conflict", i), bus.req_conflict, tv[i].ph == 5);
    end
    drive(1, 0, 0, 0, 2'd0);
    repeat (30) step();
    #2 reset = 1'b0;
    #1;
    chk("async reset phase", bus.phase, 0);
    chk("async reset remaining", bus.remaining, 0);
    chk("async reset busy", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (200) step();
    chk("held req after reset phase", bus.phase, 0);
    chk("held req after reset timeout", bus.cycle_timeout, 0);
    bus.cycle_req = 1'b0;
    step();
    bus.cycle_req = 1'b1;
    step();
    chk("re-edge phase", bus.phase, 1);
    chk("re-edge remaining", bus.remaining, 40);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) bus.cycle_req = !bus.cycle_req;
      if ($urandom_range(0, 99) == 0) bus.spin_req = !bus.spin_req;
      bus.pause = $urandom_range(0, 7) == 0;
      bus.prog_load = $urandom_range(0, 19) == 0;
      bus.prog_sel = 2'($urandom_range(0, 3));
      step();
    end
    drive(0, 0, 0, 0, 2'd0);
    repeat (2) step();
    bus.fill_value_on = 1'b1;
    repeat (24) step();
    bus.fill_value_on = 1'b0;
    repeat (4) step();
    chk("fill_fault", bus.fill_fault, FF_EXP);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/wash_timer_scheduler.md
WASH_TIMER_SCHEDULER -- requirements
Module: wash_timer_scheduler

Interface
REQ-001 Parameter: PRESCALE, default 1000, clocks per time-base tick (legal 2..65535).
REQ-002 Parameter: FILL_LIMIT, default 60, ticks fill_value_on may stay high before fault.
REQ-003 Port: clk  input  1  system clock, all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low.
REQ-005 Ports, all inputs, 1 bit: cycle_req (controller in wash cycle), spin_req (controller in spin), fill_value_on (fill valve drive), pause (freeze timing), prog_load (latch prog_sel).
REQ-006 Port: prog_sel  input  2  program select: 0 quick, 1 normal, 2 heavy, 3 illegal.
REQ-007 Ports, all outputs, 1 bit: cycle_timeout, spin_timeout, busy, req_conflict, prog_err (one-cycle pulse), fill_fault.
REQ-008 Port: remaining  output  8  ticks left in the active phase.
REQ-009 Port: phase  output  3  state encoding per REQ-011.

Function
REQ-010 Program table, cycle/spin ticks: quick 20/10, normal 40/20, heavy 80/30.
REQ-011 States: IDLE=0, CYC_RUN=1, CYC_DONE=2, SPIN_RUN=3, SPIN_DONE=4, CONFLICT=5; phase shall equal the state code.
REQ-012 IDLE->CYC_RUN on an edge sampling cycle_req=1, spin_req=0: load remaining with the program cycle value and clear the prescaler to 0.
REQ-013 IDLE->SPIN_RUN on an edge sampling spin_req=1, cycle_req=0: load the program spin value and clear the prescaler.
REQ-014 In RUN states, not paused: prescaler increments each clock; at PRESCALE-1 it wraps to 0 and issues a tick; each tick decrements remaining by 1.
REQ-015 The edge taking remaining 1->0 shall move RUN->DONE and set the matching timeout. Timeout therefore rises exactly N*PRESCALE clocks after the load edge.
REQ-016 In DONE, timeout holds high while the request stays high; request low -> IDLE and timeout low on the same edge.
REQ-017 Request dropping in a RUN state aborts: IDLE, remaining=0, no timeout.
REQ-018 pause=1 freezes prescaler and remaining in RUN states; it has no effect in other states.
REQ-019 cycle_req and spin_req both high in any state -> CONFLICT: both timeouts low, remaining=0, req_conflict=1. Exit to IDLE once both requests are low.
REQ-020 A fresh rising cycle_req (second/rinse wash) reloads the full cycle value; no carry-over.
REQ-021 prog_load=1 in IDLE with prog_sel 0..2: latch the program on the next edge.
REQ-022 prog_load=1 in IDLE with prog_sel=3: keep the previous program and pulse prog_err for one cycle.
REQ-023 prog_load outside IDLE: ignored, no prog_err.
REQ-024 busy=1 in CYC_RUN and SPIN_RUN only.

Reset
REQ-025 reset=0 asynchronously forces: IDLE, program=normal, prescaler=0, remaining=0, and all 1-bit outputs low.
REQ-026 Reset mid-run discards all timing; after release, operation needs a new request rising edge.

Configuration
REQ-027 Macro FILL_WATCHDOG_EN, when defined, adds a fill watchdog with its own free-running tick.
REQ-028 With FILL_WATCHDOG_EN: the watchdog counts ticks while fill_value_on=1 and clears when it is 0. Reaching FILL_LIMIT sets fill_fault, which is sticky until reset.
REQ-029 With FILL_WATCHDOG_EN, fill_fault=1 forces cycle_timeout and spin_timeout low and blocks IDLE exits.
REQ-030 Without FILL_WATCHDOG_EN: fill_fault is tied 0, fill_value_on is unused, and no watchdog logic is present.

Verification (PRESCALE=4, FILL_LIMIT=5)
REQ-031 Default program, cycle_req held high -> cycle_timeout rises 160 clocks after the load edge; remaining steps 40->0.
REQ-032 prog_load with prog_sel=0, then spin_req high -> spin_timeout after 40 clocks. Next, prog_sel=3 load -> prog_err pulse, and spin still takes 40.
REQ-033 Cycle run with pause high for 10 clocks midway -> timeout at 170 clocks; cycle_req dropped at clock 50 -> IDLE, no timeout.
REQ-034 cycle_req and spin_req raised together -> phase=5, req_conflict=1. Both dropped -> IDLE next edge.
REQ-035 reset pulsed low at clock 30 of a run -> immediate IDLE, outputs 0, and no timeout while cycle_req stays high until re-edged.
REQ-036 FILL_WATCHDOG_EN defined, fill_value_on high 20 clocks -> fill_fault=1 stays set; undefined build -> fill_fault stays 0.
